grid_sequencer: RTL
===================

GRID_SEQUENCER -- requirements
Module: grid_sequencer

Interface
REQ-001 Parameter: GRID_CELLS, default 25, number of cells loaded serially into the grid memory; legal range 1 to 65535.
REQ-002 Parameter: GEN_WIDTH, default 16, width of generation target and counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 load_start  input  1  single-cycle request to begin a serial grid load.
REQ-006 bit_valid  input  1  serial source has a cell bit on bit_data.
REQ-007 bit_data  input  1  cell value being offered.
REQ-008 bit_ready  output  1  sequencer accepts a bit this cycle.
REQ-009 run_start  input  1  single-cycle request to begin running generations.
REQ-010 stop  input  1  pause request during run.
REQ-011 gen_target  input  GEN_WIDTH  number of generations to run; sampled on accepted run_start.
REQ-012 load_mode  output  1  drives grid memory shift-load enable.
REQ-013 run_mode  output  1  drives grid memory parallel-load (next generation) enable.
REQ-014 serial_out  output  1  drives grid memory serial input.
REQ-015 loaded  output  1  grid holds a complete image.
REQ-016 busy  output  1  high in LOAD or RUN.
REQ-017 gen_count  output  GEN_WIDTH  generations completed in current run.
REQ-018 done  output  1  one-cycle pulse when gen_target reached.

Function
REQ-019 States: IDLE, LOAD, LOADED, RUN, DONE.
REQ-020 IDLE: load_start -> LOAD with cell counter cleared; run_start ignored.
REQ-021 LOAD: bit_ready=1; bit accepted when bit_valid && bit_ready; load_mode=1 and serial_out=bit_data combinationally in the accept cycle only; otherwise load_mode=0, serial_out=0.
REQ-022 LOAD: cell counter increments per accepted bit; accept of bit number GRID_CELLS -> LOADED next cycle; bit_ready=0 outside LOAD.
REQ-023 LOAD: load_start and run_start ignored; stop ignored.
REQ-024 LOADED: load_start -> LOAD (reload); run_start -> RUN, gen_count cleared, gen_target latched; load_start wins when both asserted.
REQ-025 LOADED: run_start with gen_target==0 -> DONE directly, no run_mode cycle.
REQ-026 RUN: run_mode=1 every cycle in state (one generation per cycle); gen_count increments each RUN cycle.
REQ-027 RUN: cycle where gen_count+1 == latched target -> DONE next cycle, gen_count holds target.
REQ-028 RUN: stop (not coinciding with final generation) -> LOADED; that cycle's generation still counts; gen_count held; later run_start restarts from 0.
REQ-029 stop coinciding with final generation -> DONE (completion wins).
REQ-030 DONE: done=1 for exactly one cycle, then LOADED; gen_count held until next run_start.
REQ-031 load_mode and run_mode never high in same cycle.
REQ-032 loaded=1 in LOADED, RUN, DONE; 0 in IDLE, LOAD.
REQ-033 gen_count wraps not required: target limits it to 2^GEN_WIDTH-1.

Reset
REQ-034 reset low: state IDLE, cell counter 0, gen_count 0, latched target 0, all outputs 0, immediately and independent of clk.
REQ-035 reset asserted mid-LOAD or mid-RUN aborts with no done pulse; grid memory contents not this block's concern.

Structure
REQ-036 Shared package conway_pkg holds state enum typedef grid_seq_state_t and default constants GRID_CELLS_DEFAULT, GEN_WIDTH_DEFAULT.
REQ-037 One sub-module, up_counter (parameterised width, clear, enable, async active-low reset), instantiated for cell count and gen_count.

Verification (GRID_CELLS=5)
REQ-038 load_start, then bits 1,0,0,1,1 with bit_valid gaps -> exactly 5 load_mode pulses matching bits, loaded=1 after 5th, bit_ready drops.
REQ-039 run_start with gen_target=3 -> run_mode high exactly 3 cycles, gen_count 1,2,3, done pulse one cycle, then LOADED.
REQ-040 run_start with gen_target=0 -> no run_mode, done pulse next cycle.
REQ-041 gen_target=10, stop on 4th RUN cycle -> gen_count=4 held, LOADED; stop with final generation of gen_target=2 -> done asserted.
REQ-042 reset low after 2 accepted bits -> all outputs 0 asynchronously, state IDLE, bits ignored until load_start.
REQ-043 load_start and run_start together in LOADED -> LOAD entered, run_mode stays 0.

Source files
------------

// File: rtl/conway_pkg.sv
// Shared types and defaults for the grid sequencer.
//   grid_seq_state_t   : sequencer FSM state encoding
//   GRID_CELLS_DEFAULT : default number of cells in a serial grid load
//   GEN_WIDTH_DEFAULT  : default width of the generation target / counter
//   CELL_CNT_WIDTH     : cell counter width, wide enough for the largest legal grid
package conway_pkg;

    localparam int unsigned GRID_CELLS_DEFAULT = 25;
    localparam int unsigned GEN_WIDTH_DEFAULT  = 16;
    localparam int unsigned CELL_CNT_WIDTH     = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StLoaded,
        StRun,
        StDone
    } grid_seq_state_t;

endpackage

// File: rtl/up_counter.sv
// Generic up counter with synchronous clear and count enable.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset, forces the count to zero
//   clr_i   : synchronous clear, has priority over en_i
//   en_i    : increment by one this cycle
//   count_o : current count
module up_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/grid_sequencer.sv
// Sequences a cellular-automaton grid memory: serial image load, then a
// bounded number of generations, one per clock.
//   clk, reset         : clock, asynchronous active-low reset
//   load_start         : begin a serial load (IDLE or LOADED)
//   bit_valid/bit_data : serial cell source; bit_ready shows acceptance
//   run_start/stop     : begin / pause a run; gen_target sampled on run_start
//   load_mode          : grid shift-load enable (accept cycles only)
//   run_mode           : grid next-generation enable
//   serial_out         : grid serial input
//   loaded, busy, done : status; done pulses once when the target is reached
//   gen_count          : generations completed in the current run
module grid_sequencer
    import conway_pkg::*;
#(
    parameter int unsigned GRID_CELLS = GRID_CELLS_DEFAULT,
    parameter int unsigned GEN_WIDTH  = GEN_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_start,
    input  logic                 bit_valid,
    input  logic                 bit_data,
    output logic                 bit_ready,
    input  logic                 run_start,
    input  logic                 stop,
    input  logic [GEN_WIDTH-1:0] gen_target,
    output logic                 load_mode,
    output logic                 run_mode,
    output logic                 serial_out,
    output logic                 loaded,
    output logic                 busy,
    output logic [GEN_WIDTH-1:0] gen_count,
    output logic                 done
);

    localparam logic [CELL_CNT_WIDTH-1:0] LastCell = CELL_CNT_WIDTH'(GRID_CELLS - 1);

    grid_seq_state_t             state_d, state_q;
    logic [GEN_WIDTH-1:0]        target_d, target_q;
    logic [CELL_CNT_WIDTH-1:0]   cell_cnt;
    logic                        cell_clr, cell_en;
    logic                        gen_clr, gen_en;
    logic [GEN_WIDTH-1:0]        gen_next;

    assign gen_next = gen_count + GEN_WIDTH'(1);

    up_counter #(
        .Width (CELL_CNT_WIDTH)
    ) u_cell_cnt (
        .clk_i   (clk),
        .rst_ni  (reset),
        .clr_i   (cell_clr),
        .en_i    (cell_en),
        .count_o (cell_cnt)
    );

    up_counter #(
        .Width (GEN_WIDTH)
    ) u_gen_cnt (
        .clk_i   (clk),
        .rst_ni  (reset),
        .clr_i   (gen_clr),
        .en_i    (gen_en),
        .count_o (gen_count)
    );

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        cell_clr   = 1'b0;
        cell_en    = 1'b0;
        gen_clr    = 1'b0;
        gen_en     = 1'b0;
        bit_ready  = 1'b0;
        load_mode  = 1'b0;
        serial_out = 1'b0;
        run_mode   = 1'b0;
        loaded     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (load_start) begin
                    state_d  = StLoad;
                    cell_clr = 1'b1;
                end
            end
            StLoad: begin
                bit_ready = 1'b1;
                busy      = 1'b1;
                if (bit_valid) begin
                    load_mode  = 1'b1;
                    serial_out = bit_data;
                    cell_en    = 1'b1;
                    if (cell_cnt == LastCell) begin
                        state_d = StLoaded;
                    end
                end
            end
            StLoaded: begin
                loaded = 1'b1;
                // Reload takes priority over a simultaneous run request.
                if (load_start) begin
                    state_d  = StLoad;
                    cell_clr = 1'b1;
                end else if (run_start) begin
                    gen_clr  = 1'b1;
                    target_d = gen_target;
                    state_d  = (gen_target == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                loaded   = 1'b1;
                busy     = 1'b1;
                run_mode = 1'b1;
                gen_en   = 1'b1;
                // Completion wins over a stop in the final generation.
                if (gen_next == target_q) begin
                    state_d = StDone;
                end else if (stop) begin
                    state_d = StLoaded;
                end
            end
            StDone: begin
                loaded  = 1'b1;
                done    = 1'b1;
                state_d = StLoaded;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

endmodule
